ultra_das_beamformer: RTL
=========================

Name: ultra_das_beamformer

Overview:
Parametrised multi-channel delay-and-sum beamformer that generalises the single-channel, fixed SAMPLE_DELAY ultrasound datapath. Each of NUM_CH channels has its own programmable delay. Delays are realised by a circular buffer per channel, and the delayed samples are summed into one widened output stream. The block sits between the per-channel sample sources (file readers or ADC front end) and downstream envelope/image logic. Processing is framed by a start/busy/done FSM.

Parameters:
NUM_CH, 4, number of receive channels (power of 2, >=2)
DATA_WIDTH, 16, signed sample width per channel
MAX_DELAY, 64, circular buffer depth per channel; the largest usable delay is MAX_DELAY-1
FRAME_LEN, 256, input beats accepted per frame
CH_W, $clog2(NUM_CH), channel index and sum growth width
DLY_W, 8, width of the delay config field

Ports:
clk  in  1  system clock; all logic is rising-edge
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  delay write strobe; honoured only in IDLE
cfg_ch  in  CH_W  channel index for the delay write
cfg_delay  in  DLY_W  requested delay, in samples
start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE
in_valid  in  1  in_data holds a valid beat
in_ready  out  1  high only in RUN
in_data  in  NUM_CH*DATA_WIDTH  packed samples; ch k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  out_data valid this cycle (no backpressure)
out_data  out  DATA_WIDTH+CH_W  signed delay-and-sum result
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0, out_data=0, in_ready=0, busy=0, done=0; write pointer=0; beat counter=0; all delay regs=0. Buffer contents need not be cleared.
- Delay config: in IDLE, cfg_we writes delay[cfg_ch] = min(cfg_delay, MAX_DELAY-1). cfg_we in RUN or DRAIN is ignored.
- max_d is the maximum of the effective delays, computed combinationally or registered, and is stable from start onward.
- FSM IDLE:
  - start -> RUN; clears the beat counter n and the write pointer.
  - start and cfg_we in the same cycle: the cfg write lands first and is used for the frame.
- FSM RUN:
  - A beat is accepted when in_valid && in_ready.
  - On each accepted beat n, the sample is written to each channel buffer at wptr, and then wptr = (wptr+1) mod MAX_DELAY.
  - in_valid low: no write, no output, counter holds.
  - After accepting beat FRAME_LEN-1: go to DRAIN if max_d>0; otherwise go to IDLE with done=1 in the next cycle.
- FSM DRAIN:
  - Runs exactly max_d cycles. Each cycle is an internal beat n = FRAME_LEN..FRAME_LEN+max_d-1, with the input treated as zero on all channels.
  - in_ready=0 throughout.
  - After the last drain beat: go to IDLE and pulse done for 1 cycle, coincident with the cycle after the last out_valid.
- Output:
  - For every beat n (accepted or drain), out_valid=1 exactly one cycle later.
  - out_data = sum over k of s_k, where s_k = x_k[n - delay[k]] if n >= delay[k], else 0.
  - x_k[m] for m >= FRAME_LEN is zero.
  - Read address = (wptr - delay[k]) mod MAX_DELAY; delay 0 reads the current beat (bypass, not the buffer).
  - Arithmetic: sign-extend each sample to DATA_WIDTH+CH_W and add. No overflow or saturation is possible.
  - The output register holds its value when out_valid=0.
- Total out_valid beats per frame = FRAME_LEN + max_d.
- start during RUN or DRAIN is ignored. Reset mid-frame aborts immediately and no done is issued.

Test Plan:
- Bench parameters: NUM_CH=4, DATA_WIDTH=16, MAX_DELAY=64, FRAME_LEN=8.
- All delays 0; every beat ch0..3 = {1,2,3,4} -> 8 out_valid beats, each out_data=10, each one cycle after its accepted beat; no DRAIN; done the cycle after the 8th output.
- Delays {0,1,2,3}; all channels = n+1 at beat n -> outputs 1,3,6,10,14,18,22,26, then drain outputs 21,15,8; 11 out_valid beats in total; done after 8.
- Gaps: in_valid toggles 1,0,1,0 with constant {1,2,3,4} and delays 0 -> out_valid only follows accepted beats, in_ready=1 throughout RUN, counter advances only on accepts, still 8 outputs.
- cfg_delay=200 on ch2, all other delays 0, ch2 = n+1 -> effective delay 63; max_d=63; out_data=0 for n<63 and drain runs 63 cycles (71 outputs).
- Signed extremes: all channels = -32768 (0x8000), delays 0 -> out_data = -131072 (18'h20000); all = 32767 -> 131068.
- Reset asserted mid-RUN at beat 4 (async, not clock-aligned) -> outputs immediately zero, IDLE, delays 0, no done. A cfg_we issued in RUN before the reset is ignored. A new start runs a clean frame.

Source files
------------

// File: rtl/ultra_das_beamformer.sv
// ultra_das_beamformer
// Multi-channel delay-and-sum beamformer. Each channel has its own programmable
// delay, which is realised with a per-channel circular buffer. Processing is
// framed by a start/busy/done FSM.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for start; delay registers writable
//   RUN     | accepting FRAME_LEN input beats (in_ready high)
//   DRAIN   | max_d internal zero-input beats flush the delayed tails
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   cfg_we     in   delay write strobe (IDLE only)
//   cfg_ch     in   channel index for the delay write
//   cfg_delay  in   requested delay; clamped to MAX_DELAY-1
//   start      in   frame start pulse (IDLE only)
//   in_valid   in   in_data holds a valid beat
//   in_ready   out  high in RUN
//   in_data    in   packed samples, ch k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  out_data valid this cycle
//   out_data   out  signed delay-and-sum result
//   busy       out  high in RUN or DRAIN
//   done       out  one-cycle pulse, the cycle after the last out_valid
module ultra_das_beamformer #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_DELAY  = 64,
    parameter int FRAME_LEN  = 256,
    parameter int CH_W       = $clog2(NUM_CH),
    parameter int DLY_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_we,
    input  logic [CH_W-1:0]                cfg_ch,
    input  logic [DLY_W-1:0]               cfg_delay,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    output logic [DATA_WIDTH+CH_W-1:0]     out_data,
    output logic                           busy,
    output logic                           done
);

    localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int OW = DATA_WIDTH + CH_W;
    localparam int NW = $clog2(FRAME_LEN + MAX_DELAY) + 1;

    localparam logic [AW-1:0]    PTR_LAST  = AW'(MAX_DELAY - 1);
    localparam logic [NW-1:0]    N_LAST    = NW'(FRAME_LEN - 1);
    localparam logic [NW-1:0]    N_FRAME   = NW'(FRAME_LEN);
    localparam logic [DLY_W-1:0] DLY_CLAMP = DLY_W'(MAX_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [AW-1:0]                 r_delay [NUM_CH];
    logic [AW-1:0]                 r_wptr;
    logic [NW-1:0]                 r_n;
    logic signed [DATA_WIDTH-1:0]  r_mem [NUM_CH][MAX_DELAY];
    logic                          r_out_valid;
    logic [OW-1:0]                 r_out_data;
    logic                          r_fin;
    logic                          r_done;

    logic [AW-1:0]                 w_max_d;
    logic [AW-1:0]                 w_cfg_eff;
    logic [AW-1:0]                 w_wptr_nxt;
    logic                          w_acc;
    logic                          w_beat;
    logic                          w_run_last;
    logic                          w_drain_last;
    logic                          w_fin;
    logic                          w_in_ready;
    logic                          w_busy;
    logic signed [DATA_WIDTH-1:0]  w_x   [NUM_CH];
    logic signed [DATA_WIDTH-1:0]  w_tap [NUM_CH];
    logic [AW-1:0]                 w_rd  [NUM_CH];
    logic signed [OW-1:0]          w_sum;

    always_comb begin
        w_max_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_delay[k] > w_max_d) begin
                w_max_d = r_delay[k];
            end
        end
    end

    assign w_cfg_eff  = (cfg_delay > DLY_CLAMP) ? AW'(DLY_CLAMP) : AW'(cfg_delay);
    assign w_wptr_nxt = (r_wptr == PTR_LAST) ? '0 : r_wptr + AW'(1);

    assign w_acc        = (r_state == S_RUN) && in_valid;
    assign w_beat       = w_acc || (r_state == S_DRAIN);
    assign w_run_last   = w_acc && (r_n == N_LAST);
    assign w_drain_last = (r_state == S_DRAIN) &&
                          (r_n == N_FRAME + NW'(w_max_d) - NW'(1));
    // Final beat of the frame; done follows its output by one cycle.
    assign w_fin        = (w_run_last && (w_max_d == '0)) || w_drain_last;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_run_last) begin
                    w_state_nxt = (w_max_d != '0) ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_drain_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-channel tap. Delay 0 bypasses the buffer; taps that would reach
    // before the start of the frame read as zero, so stale buffer contents
    // are never used.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_x[k]   = (r_state == S_RUN) ? in_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
            w_rd[k]  = (r_wptr >= r_delay[k]) ? (r_wptr - r_delay[k])
                                              : (r_wptr + AW'(MAX_DELAY) - r_delay[k]);
            w_tap[k] = '0;
            if (r_delay[k] == '0) begin
                w_tap[k] = w_x[k];
            end else if (r_n >= NW'(r_delay[k])) begin
                w_tap[k] = r_mem[k][w_rd[k]];
            end
            w_sum = w_sum + OW'(w_tap[k]);
        end
    end

    // Drain beats write zeros so that later taps see x[m] = 0 past the frame.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_mem[k][r_wptr] <= w_x[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_n         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_fin       <= 1'b0;
            r_done      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_delay[k] <= '0;
            end
        end else begin
            r_out_valid <= w_beat;
            if (w_beat) begin
                r_out_data <= w_sum;
            end
            r_fin  <= w_fin;
            r_done <= r_fin;
            if (r_state == S_IDLE) begin
                if (cfg_we) begin
                    r_delay[cfg_ch] <= w_cfg_eff;
                end
                if (start) begin
                    r_n    <= '0;
                    r_wptr <= '0;
                end
            end else if (w_beat) begin
                r_n    <= r_n + NW'(1);
                r_wptr <= w_wptr_nxt;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule
